// File: rtl/barrett_precompute_pkg.sv
// Shared Barrett reduction constants and the precompute FSM state type.
// The reducer imports the same DATA_W so the two blocks agree on port widths.
package barrett_precompute_pkg;

  // Width of the modulus / constant ports shared with the pipelined reducer.
  localparam int BARRETT_DATA_W = 64;

  // Largest legal modulus bit length. With k <= 32, mu fits in k+2 bits and
  // the 2k shift applied to the 128-bit x*mu product stays in range.
  localparam int BARRETT_MAX_MOD_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BITLEN = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } bp_state_e;

endpackage

// File: rtl/barrett_precompute_bitlen.sv
// Combinational leading-one detector: returns the index of the highest set
// bit plus one, so a zero input gives zero.
module barrett_precompute_bitlen #(
  parameter int DATA_W = 64,
  parameter int K_W    = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] m_i,
  output logic [K_W-1:0]    k_o
);

  // Scan upward; the last set bit seen wins, giving the highest one.
  always_comb begin
    k_o = '0;
    for (int b = 0; b < DATA_W; b++) begin
      if (m_i[b]) k_o = K_W'(b + 1);
    end
  end

endmodule

// File: rtl/barrett_precompute.sv
// Barrett constant precompute: from modulus m produce k = bitlen(m) and
// mu = floor(2^(2k) / m) using a bit-serial restoring divider.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start_i; outputs hold the previous result
// ST_BITLEN | one cycle: find k, range-check m, prime the divider
// ST_DIVIDE | 2k+1 cycles: one quotient bit of 2^(2k)/m per cycle
// ST_DONE   | valid_o pulse; accepts a new start_i like ST_IDLE
module barrett_precompute
  import barrett_precompute_pkg::*;
#(
  parameter int DATA_W       = BARRETT_DATA_W,
  parameter int MAX_MOD_BITS = BARRETT_MAX_MOD_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] m_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic              error_o,
  output logic [DATA_W-1:0] m_bl_o,
  output logic [DATA_W-1:0] mu_o
);

  localparam int K_W   = $clog2(DATA_W + 1);
  localparam int CNT_W = $clog2(2 * MAX_MOD_BITS + 1);
  // Remainder stays below m < 2^MAX_MOD_BITS; one extra bit for the shift,
  // one more so the compare can never wrap.
  localparam int R_W   = MAX_MOD_BITS + 2;

  bp_state_e         state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] m_bl_q, m_bl_d;
  logic [DATA_W-1:0] mu_q, mu_d;

  logic [K_W-1:0]    k_det;
  logic [R_W-1:0]    r_sh;
  logic [R_W-1:0]    m_low;
  logic [DATA_W-1:0] q_next;
  logic              first_step;

  barrett_precompute_bitlen #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_bitlen (
    .m_i (m_q),
    .k_o (k_det)
  );

  // Next-state, divider step and result capture.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    k_d        = k_q;
    r_d        = r_q;
    q_d        = q_q;
    i_d        = i_q;
    error_d    = error_q;
    m_bl_d     = m_bl_q;
    mu_d       = mu_q;
    // The dividend 2^(2k) contributes a single 1, on the very first step.
    first_step = (i_q == CNT_W'({k_q, 1'b0}));
    r_sh       = {r_q[R_W-2:0], first_step};
    m_low      = m_q[R_W-1:0];
    q_next     = {q_q[DATA_W-2:0], 1'b0};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          m_d     = m_i;
          error_d = 1'b0;
          state_d = ST_BITLEN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_BITLEN: begin
        if ((m_q == '0) || (k_det > K_W'(MAX_MOD_BITS))) begin
          error_d = 1'b1;
          m_bl_d  = '0;
          mu_d    = '0;
          state_d = ST_DONE;
        end else begin
          k_d     = k_det;
          r_d     = '0;
          q_d     = '0;
          i_d     = CNT_W'({k_det, 1'b0});
          state_d = ST_DIVIDE;
        end
      end

      ST_DIVIDE: begin
        if (r_sh >= m_low) begin
          r_d    = r_sh - m_low;
          q_next = {q_q[DATA_W-2:0], 1'b1};
        end else begin
          r_d    = r_sh;
        end
        q_d = q_next;
        if (i_q == '0) begin
          mu_d    = q_next;
          m_bl_d  = {{(DATA_W-K_W){1'b0}}, k_q};
          state_d = ST_DONE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      i_q     <= '0;
      error_q <= 1'b0;
      m_bl_q  <= '0;
      mu_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      r_q     <= r_d;
      q_q     <= q_d;
      i_q     <= i_d;
      error_q <= error_d;
      m_bl_q  <= m_bl_d;
      mu_q    <= mu_d;
    end
  end

  assign busy_o  = (state_q == ST_BITLEN) || (state_q == ST_DIVIDE);
  assign valid_o = (state_q == ST_DONE);
  assign error_o = error_q;
  assign m_bl_o  = m_bl_q;
  assign mu_o    = mu_q;

endmodule

// File: tb/tb_barrett_precompute.sv
// Self-checking bench for barrett_precompute against an arithmetic model.
module tb_barrett_precompute;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] m_i = '0;
  logic        busy_o, valid_o, error_o;
  logic [63:0] m_bl_o, mu_o;

  int n_chk  = 0;
  int n_fail = 0;

  barrett_precompute dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .m_i     (m_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .error_o (error_o),
    .m_bl_o  (m_bl_o),
    .mu_o    (mu_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: k from the top set bit, mu by wide integer division.
  function automatic void model(input logic [63:0] m, output bit err,
                                output logic [63:0] k, output logic [63:0] mu,
                                output int lat);
    int kk;
    logic [127:0] num;
    kk = 0;
    for (int b = 0; b < 64; b++) if (m[b]) kk = b + 1;
    if (m == 0 || kk > 32) begin
      err = 1'b1; k = '0; mu = '0; lat = 2;
    end else begin
      num = 128'd1 << (2 * kk);
      err = 1'b0; k = 64'(kk); mu = 64'(num / {64'd0, m}); lat = 2 * kk + 3;
    end
  endfunction

  // Present start_i for one edge; returns #1 after the accept edge (cycle 1).
  task automatic do_start(input logic [63:0] m);
    @(negedge clk_i);
    start_i = 1'b1;
    m_i     = m;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    m_i     = {$urandom, $urandom};
  endtask

  // Wait for valid_o and check the result. Optionally pulse an ignored start
  // mid-run, and optionally chain a new start in the DONE cycle.
  task automatic collect(input logic [63:0] m, input int pulse_at,
                         input logic [63:0] m_pulse, input bit chain,
                         input logic [63:0] m_chain, input string tag,
                         output logic [63:0] got_k, output logic [63:0] got_mu);
    bit          e_err;
    logic [63:0] e_k, e_mu;
    int          e_lat, cyc;
    bit          busy_ok;
    model(m, e_err, e_k, e_mu, e_lat);
    cyc = 1;
    busy_ok = 1'b1;
    while (!valid_o && cyc < 200) begin
      if (!busy_o) busy_ok = 1'b0;
      if (cyc == pulse_at) begin
        start_i = 1'b1;
        m_i     = m_pulse;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(e_lat));
    chk({tag, " busy during run"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, " valid"}, {63'd0, valid_o}, 64'd1);
    chk({tag, " busy at done"}, {63'd0, busy_o}, 64'd0);
    chk({tag, " error"}, {63'd0, error_o}, {63'd0, e_err});
    chk({tag, " m_bl"}, m_bl_o, e_k);
    chk({tag, " mu"}, mu_o, e_mu);
    got_k  = m_bl_o;
    got_mu = mu_o;
    if (chain) begin
      start_i = 1'b1;
      m_i     = m_chain;
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk({tag, " valid one cycle"}, {63'd0, valid_o}, 64'd0);
    chk({tag, " mu held"}, mu_o, e_mu);
  endtask

  task automatic run(input logic [63:0] m, input string tag);
    logic [63:0] k, mu;
    do_start(m);
    collect(m, -1, '0, 1'b0, '0, tag, k, mu);
  endtask

  initial begin
    logic [63:0] k, mu, m, xq, xr;
    int kr;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst busy", {63'd0, busy_o}, 64'd0);
    chk("rst valid", {63'd0, valid_o}, 64'd0);
    chk("rst error", {63'd0, error_o}, 64'd0);
    chk("rst m_bl", m_bl_o, 64'd0);
    chk("rst mu", mu_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic and boundary cases.
    do_start(64'd13);
    collect(64'd13, 3, 64'd7, 1'b1, 64'd7, "m13", k, mu);
    collect(64'd7, -1, '0, 1'b0, '0, "m7 chained", k, mu);
    run(64'd1, "m1");
    run(64'h8000_0000, "m2^31");
    run(64'hFFFF_FFFF, "mFFFFFFFF");
    run(64'h8000_0001, "m80000001");
    run(64'd0, "m0");
    run(64'h1_0000_0000, "m2^32");

    // A following good start clears error_o immediately after accept.
    do_start(64'd13);
    chk("error cleared on accept", {63'd0, error_o}, 64'd0);
    collect(64'd13, -1, '0, 1'b0, '0, "m13 after err", k, mu);

    // Constants drive a Barrett reduction of x=1000 to 1000 mod 13.
    xq = (64'd1000 * mu) >> (2 * k);
    xr = 64'd1000 - xq * 64'd13;
    while (xr >= 64'd13) xr = xr - 64'd13;
    chk("reduce 1000 mod 13", xr, 64'(1000 % 13));

    // Randomized moduli, mostly legal, some out of range.
    for (int n = 0; n < 24; n++) begin
      kr = int'($urandom_range(1, 40));
      m  = {$urandom, $urandom};
      if (kr < 64) m = m & ((64'd1 << kr) - 64'd1);
      m[kr-1] = 1'b1;
      run(m, $sformatf("rand%0d", n));
    end

    // Synchronous reset mid-divide overrides a concurrent start.
    do_start(64'h8000_0001);
    repeat (5) @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    start_i = 1'b1;
    m_i     = 64'd7;
    @(posedge clk_i);
    #1;
    chk("midrst busy", {63'd0, busy_o}, 64'd0);
    chk("midrst valid", {63'd0, valid_o}, 64'd0);
    chk("midrst error", {63'd0, error_o}, 64'd0);
    chk("midrst m_bl", m_bl_o, 64'd0);
    chk("midrst mu", mu_o, 64'd0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("post rst idle busy", {63'd0, busy_o}, 64'd0);
    chk("post rst idle valid", {63'd0, valid_o}, 64'd0);
    run(64'd5, "m5 after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/barrett_precompute.md
Name: barrett_precompute

Overview:
Sequential precompute engine for the Barrett reduction datapath. It takes a modulus m and produces the two constants the pipelined reducer consumes: bit length k = m_bl and mu = floor(2^(2k) / m).
- Bit-serial restoring divider; no multipliers.
- Run once per modulus change, ahead of the reducer; outputs are held stable for it.

Parameters:
- DATA_W, 64, width of the m, m_bl and mu ports (matches the reducer ports).
- MAX_MOD_BITS, 32, largest legal bit length of m. This keeps mu within k+2 bits and keeps the 2k shift of the 128-bit x*mu product legal.

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only when ready (IDLE or DONE)
- m_i  in  DATA_W  modulus; captured on the accepted start_i edge
- busy_o  out  1  high from the accept edge until the DONE state is entered
- valid_o  out  1  one-cycle pulse; m_bl_o, mu_o and error_o are valid in this cycle
- error_o  out  1  m == 0 or bitlen(m) > MAX_MOD_BITS; held until the next accept
- m_bl_o  out  DATA_W  bit length k, zero-extended; held until the next accept
- mu_o  out  DATA_W  floor(2^(2k)/m); held until the next accept

Behaviour:
- Reset: rst_i high at a clock edge forces the following, overriding any operation in flight; no partial results leak out.
  - state IDLE, busy_o=0, valid_o=0, error_o=0
  - m_bl_o=0, mu_o=0
  - internal remainder, quotient and counter cleared
- States: IDLE, BITLEN, DIVIDE, DONE.
- IDLE:
  - start_i=1 latches m_i into m_q, sets busy_o=1 and moves to BITLEN.
  - Clears error_o; m_bl_o and mu_o keep their old values until overwritten.
- BITLEN (1 cycle):
  - k = index of the highest set bit of m_q, plus 1.
  - If m_q==0 or k>MAX_MOD_BITS: move to DONE with error_o=1, m_bl_o=0, mu_o=0.
  - Otherwise: store k, set remainder r=0 and quotient q=0, load counter i=2k, move to DIVIDE.
- DIVIDE (2k+1 cycles, i = 2k down to 0):
  - r' = (r<<1) | (i==2k ? 1 : 0). The dividend is 2^(2k), so its only 1 bit is the first one.
  - If r' >= m_q: r = r' - m_q and q[i] = 1; else r = r' and q[i] = 0.
  - Width: r is MAX_MOD_BITS+2 bits, so the compare never overflows.
  - When i==0: write q to mu_o and k to m_bl_o, then move to DONE.
- DONE:
  - valid_o=1 for exactly this cycle; busy_o=0.
  - Accepts start_i exactly like IDLE, so back-to-back requests are possible.
  - Without start_i it moves to IDLE.
- Latency from the accept edge to the valid_o cycle:
  - normal case: 2k+3 cycles (k=32 gives 67)
  - error case: 2 cycles
- start_i while busy_o=1 is ignored; m_i changes after the accept are ignored.
- Range guarantee: mu <= 2^(k+1), which fits in DATA_W when k <= 32. Upper mu_o bits are zero.
- Boundary cases:
  - m=1 gives k=1, mu=4.
  - m a power of two, 2^(k-1), gives mu=2^(k+1).

Decomposition:
- The shared multiplier/Barrett package holds:
  - the state enum typedef
  - MAX_MOD_BITS
  - the DATA_W constant, so the reducer and this block agree
- One natural sub-module: bitlen_detect, a combinational leading-one detector. It maps DATA_W bits to k, with m=0 giving 0.
- The divider step and FSM stay in the top module.

Test Plan:
- Reset: hold rst_i for 3 cycles -> all outputs 0; then assert start_i during DIVIDE with rst_i=1 -> state returns to IDLE and outputs are 0 on the next cycle.
- m=13, start at cycle 0 -> valid_o at cycle 11 with m_bl_o=4, mu_o=19, error_o=0; busy_o high for cycles 1..10.
- m=1 -> m_bl_o=1, mu_o=4 at cycle 5. m=0x8000_0000 -> m_bl_o=32, mu_o=0x2_0000_0000 at cycle 67.
- m=0xFFFF_FFFF -> mu_o=0x1_0000_0001. m=0x8000_0001 -> mu_o=0x1_FFFF_FFFC. Both have m_bl_o=32 and valid at cycle 67.
- m=0 and m=0x1_0000_0000 -> error_o=1, m_bl_o=0, mu_o=0, valid at cycle 2. A following m=13 start clears error_o.
- Pulse start_i with m=7 mid-run on m=13 -> ignored, result is still 19. Start again in the DONE cycle with m=7 -> accepted, giving m_bl_o=3, mu_o=9. Feed the results to the reducer with x=1000 -> remainder 1000 mod 13 = 12.
